load_store_unit: RTL and testbench

// - Sits between the RV32I multicycle control/datapath and the word-wide, negedge-clocked Memory block.
// - Converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses.
// - Extracts and sign/zero-extends load data.
// - Implements SB/SH as a read-modify-write, because Memory has no byte enables.

---
 rtl/lsu_pkg.sv | 50 +++++
 rtl/lsu_align.sv | 44 ++++
 rtl/load_store_unit.sv | 132 +++++++++++++
 tb/tb_load_store_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, funct3 width codes,
// and the alignment/encoding legality check.
package lsu_pkg;

    localparam int unsigned WORD_OFFSET = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_f3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_f3_t;

    function automatic logic access_err(input logic we, input logic [2:0] f3,
                                        input logic [1:0] lo);
        logic e;
        e = 1'b1;
        if (we) begin
            case (f3)
                SB:      e = 1'b0;
                SH:      e = lo[0];
                SW:      e = |lo;
                default: e = 1'b1;
            endcase
        end else begin
            case (f3)
                LB, LBU: e = 1'b0;
                LH, LHU: e = lo[0];
                LW:      e = |lo;
                default: e = 1'b1;
            endcase
        end
        return e;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends load data from a memory word,
// and merges byte/halfword store data into a fetched word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] mem_word_i,
    input  logic [31:0] store_data_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = mem_word_i[{addr_lo_i, 3'b000} +: 8];
        half_v = mem_word_i[{addr_lo_i[1], 4'b0000} +: 16];

        load_data_o = mem_word_i;
        case (funct3_i)
            LB:      load_data_o = {{24{byte_v[7]}}, byte_v};
            LH:      load_data_o = {{16{half_v[15]}}, half_v};
            LBU:     load_data_o = {24'h000000, byte_v};
            LHU:     load_data_o = {16'h0000, half_v};
            default: load_data_o = mem_word_i;
        endcase

        store_word_o = store_data_i;
        case (funct3_i)
            SB: begin
                store_word_o = mem_word_i;
                store_word_o[{addr_lo_i, 3'b000} +: 8] = store_data_i[7:0];
            end
            SH: begin
                store_word_o = mem_word_i;
                store_word_o[{addr_lo_i[1], 4'b0000} +: 16] = store_data_i[15:0];
            end
            default: store_word_o = store_data_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-wide, negedge-clocked Memory.
// Optional macro LSU_ADDR_CHECK_EN: flag nonzero address bits above the memory range as errors.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned WORDS      = 10,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [2:0]            funct3_i,
    input  logic [31:0]           addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [WORDS-1:0]      mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  mem_wr_no,
    output logic                  mem_rd_no,
    input  logic [DATA_WIDTH-1:0] mem_data_i
);

    localparam int unsigned AW = WORDS + WORD_OFFSET;

`ifdef LSU_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [2:0]            f3_q, f3_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  req_err;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] store_word;

    lsu_align u_align (
        .funct3_i     (f3_q),
        .addr_lo_i    (addr_q[1:0]),
        .mem_word_i   (mem_data_i),
        .store_data_i (wdata_q),
        .load_data_o  (load_data),
        .store_word_o (store_word)
    );

    assign req_err = access_err(we_i, funct3_i, addr_i[1:0]) |
                     (ADDR_CHECK & (|addr_i[31:AW]));

    // word_q carries the final write word: wdata for SW, the merged word for SB/SH.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    f3_d    = funct3_i;
                    addr_d  = addr_i[AW-1:0];
                    wdata_d = wdata_i;
                    word_d  = wdata_i;
                    err_d   = req_err;
                    if (req_err)
                        state_d = DONE;
                    else if (we_i && (funct3_i == SW))
                        state_d = WRITE;
                    else
                        state_d = READ;
                end
            end
            READ: begin
                if (we_q) begin
                    word_d  = store_word;
                    state_d = WRITE;
                end else begin
                    rdata_d = load_data;
                    state_d = DONE;
                end
            end
            WRITE:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);
    assign err_o      = (state_q == DONE) & err_q;
    assign rdata_o    = rdata_q;
    assign mem_addr_o = addr_q[AW-1:WORD_OFFSET];
    assign mem_rd_no  = (state_q != READ);
    assign mem_wr_no  = (state_q != WRITE);
    assign mem_data_o = (state_q == WRITE) ? word_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit with a negedge Memory model
// and a word-array reference model of architectural load/store behaviour.
module tb_load_store_unit;

    logic        clk;
    logic        reset_ni;
    logic        req_i;
    logic        we_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] rdata_o;
    logic [9:0]  mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_wr_no;
    logic        mem_rd_no;
    logic [31:0] mem_data_i;

    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] exp_rdata;

    int unsigned n_total;
    int unsigned n_pass;

    load_store_unit #(.WORDS(10), .DATA_WIDTH(32)) dut (
        .clk_i      (clk),
        .reset_ni   (reset_ni),
        .req_i      (req_i),
        .we_i       (we_i),
        .funct3_i   (funct3_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .rdata_o    (rdata_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_wr_no  (mem_wr_no),
        .mem_rd_no  (mem_rd_no),
        .mem_data_i (mem_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory block: acts on the falling edge.
    always @(negedge clk) begin
        if (!mem_wr_no) mem[mem_addr_o] <= mem_data_o;
        if (!mem_rd_no) mem_data_i <= mem[mem_addr_o];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic bit model_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
        bit e;
`ifdef LSU_ADDR_CHECK_EN
        if (a[31:12] != 0) return 1'b1;
`endif
        if (f3 == 3'd0 || (f3 == 3'd4 && !we)) e = 0;
        else if (f3 == 3'd1 || (f3 == 3'd5 && !we)) e = (a % 2) != 0;
        else if (f3 == 3'd2) e = (a % 4) != 0;
        else e = 1;
        return e;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3,
                                               input logic [1:0] off);
        logic [31:0] s;
        int v;
        if (f3 == 3'd0 || f3 == 3'd4) begin
            s = w >> (8 * off);
            v = int'(s[7:0]);
            if (f3 == 3'd0 && v >= 128) v -= 256;
            return 32'(v);
        end
        if (f3 == 3'd1 || f3 == 3'd5) begin
            s = w >> (16 * off[1]);
            v = int'(s[15:0]);
            if (f3 == 3'd1 && v >= 32768) v -= 65536;
            return 32'(v);
        end
        return w;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] w, input logic [2:0] f3,
                                                input logic [1:0] off, input logic [31:0] d);
        logic [31:0] mask;
        if (f3 == 3'd2) return d;
        mask = (f3 == 3'd0) ? (32'hFF << (8 * off)) : (32'hFFFF << (16 * off[1]));
        return (w & ~mask) | ((d << ((f3 == 3'd0) ? 8 * off : 16 * off[1])) & mask);
    endfunction

    // Called at posedge+1 with the DUT idle.
    task automatic run_op(input bit we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input bit hold);
        bit          e;
        int unsigned exp_lat, exp_rd, exp_wr, n, rd, wr, both, lat;
        bit          seen, err_seen;
        logic [31:0] wd, exp_wd;
        int unsigned idx;
        idx      = int'(a[11:2]);
        e        = model_err(we, f3, a);
        exp_lat  = e ? 1 : (we ? ((f3 == 3'd2) ? 2 : 3) : 2);
        exp_rd   = (e || (we && f3 == 3'd2)) ? 0 : 1;
        exp_wr   = (!e && we) ? 1 : 0;
        exp_wd   = model_store(ref_mem[idx], f3, a[1:0], d);

        we_i = we; funct3_i = f3; addr_i = a; wdata_i = d; req_i = 1'b1;
        @(posedge clk); #1;
        if (!hold) req_i = 1'b0;
        n = 1; rd = 0; wr = 0; both = 0; seen = 0; err_seen = 0; lat = 0; wd = '0;
        while (n <= 8) begin
            if (!mem_rd_no) rd++;
            if (!mem_wr_no) begin wr++; wd = mem_data_o; end
            if (!mem_rd_no && !mem_wr_no) both++;
            if (done_o) begin seen = 1; lat = n; err_seen = err_o; break; end
            @(posedge clk); #1;
            n++;
        end
        req_i = 1'b0;
        check("done_seen", 32'(seen), 32'd1);
        check("latency", lat, exp_lat);
        check("err", 32'(err_seen), 32'(e));
        check("rd_cycles", rd, exp_rd);
        check("wr_cycles", wr, exp_wr);
        check("strobe_overlap", both, 0);
        if (exp_wr != 0) check("wr_data", wd, exp_wd);

        if (!e && we) ref_mem[idx] = exp_wd;
        if (!e && !we) exp_rdata = model_load(ref_mem[idx], f3, a[1:0]);

        @(posedge clk); #1;
        check("done_single", 32'(done_o), 32'd0);
        check("idle_after", 32'(busy_o), 32'd0);
        check("rdata", rdata_o, exp_rdata);
    endtask

    initial begin
        int unsigned nbad;
        bit          rwe;
        logic [2:0]  rf3;
        logic [31:0] ra;
        logic [19:0] hi;
        n_total = 0; n_pass = 0;
        reset_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; funct3_i = '0; addr_i = '0; wdata_i = '0;
        exp_rdata = '0;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[10] = 32'h55AA3312;
        ref_mem[10] = 32'h55AA3312;

        @(posedge clk); @(posedge clk); #1;
        check("rst_busy", 32'(busy_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_wr_no", 32'(mem_wr_no), 1);
        check("rst_rd_no", 32'(mem_rd_no), 1);
        check("rst_mem_addr", 32'(mem_addr_o), 0);
        check("rst_mem_data", mem_data_o, 0);
        reset_ni = 1'b1;
        @(posedge clk); #1;

        run_op(0, 3'b010, 32'h28, 0, 0);
        check("lw_0x28", rdata_o, 32'h55AA3312);
        run_op(0, 3'b000, 32'h2A, 0, 0);
        check("lb_0x2a", rdata_o, 32'hFFFFFFAA);
        run_op(0, 3'b100, 32'h2A, 0, 0);
        check("lbu_0x2a", rdata_o, 32'h000000AA);
        run_op(0, 3'b001, 32'h2A, 0, 0);
        check("lh_0x2a", rdata_o, 32'h000055AA);
        run_op(0, 3'b001, 32'h28, 0, 0);
        check("lh_0x28", rdata_o, 32'h00003312);
        run_op(1, 3'b000, 32'h29, 32'h000000EE, 0);
        run_op(0, 3'b010, 32'h28, 0, 0);
        check("lw_after_sb", rdata_o, 32'h55AAEE12);

        run_op(0, 3'b010, 32'h2A, 0, 0);
        run_op(1, 3'b001, 32'h29, 32'h1234, 0);
        run_op(0, 3'b011, 32'h28, 0, 0);
        check("mem10_after_err", mem[10], 32'h55AAEE12);

        // Reset in the READ cycle of an SH read-modify-write.
        we_i = 1'b1; funct3_i = 3'b001; addr_i = 32'h28; wdata_i = 32'hBEEF; req_i = 1'b1;
        @(posedge clk); #1;
        req_i = 1'b0;
        check("sh_in_read", 32'(mem_rd_no), 0);
        #2 reset_ni = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy_o), 0);
        check("rst_mid_rd_no", 32'(mem_rd_no), 1);
        check("rst_mid_wr_no", 32'(mem_wr_no), 1);
        check("rst_mid_done", 32'(done_o), 0);
        @(posedge clk); #1;
        reset_ni = 1'b1;
        exp_rdata = '0;
        @(posedge clk); #1;
        check("rst_mid_no_done", 32'(done_o), 0);
        check("rst_mid_mem10", mem[10], 32'h55AAEE12);

        run_op(0, 3'b010, 32'h28, 0, 1);
        run_op(0, 3'b010, 32'h00001028, 0, 0);

        for (int k = 0; k < 80; k++) begin
            rwe = 1'($urandom_range(0, 1));
            rf3 = 3'($urandom_range(0, 7));
            hi  = ($urandom_range(0, 7) == 0) ? 20'($urandom) : 20'h0;
            ra  = {hi, 10'(8 + $urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            run_op(rwe, rf3, ra, $urandom, 0);
        end

        nbad = 0;
        for (int i = 0; i < 1024; i++)
            if (mem[i] !== ref_mem[i]) nbad++;
        check("mem_final", nbad, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
